// File: rtl/udivider_seq.sv
// udivider_seq: iterative unsigned divider using restoring shift-subtract.
// One quotient bit is resolved per clock. A start accepted while ready
// yields done WIDTH clocks later. Results stay on the outputs until the
// next done pulse.
module udivider_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q,     state_d;
  logic [WIDTH-1:0] divisor_q,   divisor_d;
  logic [WIDTH-1:0] rem_q,       rem_d;
  logic [WIDTH-1:0] quo_q,       quo_d;
  logic [CW-1:0]    cnt_q,       cnt_d;
  logic [WIDTH-1:0] quotient_q,  quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q,       dbz_d;

  logic [WIDTH-1:0] shifted_lo;
  logic             ge;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  // One restoring step on the partial remainder and the quotient accumulator.
  always_comb begin
    // The shifted remainder is {rem_q[WIDTH-1], shifted_lo}, which is WIDTH+1 bits.
    // Its top bit is set only when the value is at least 2^WIDTH, which exceeds
    // any divisor. That bit plus a WIDTH-bit compare is therefore the full-width
    // comparison. When ge holds, the true difference is below 2^WIDTH, so a
    // WIDTH-bit subtract is exact.
    shifted_lo = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
    ge         = rem_q[WIDTH-1] | (shifted_lo >= divisor_q);
    diff       = shifted_lo - divisor_q;
    rem_next   = ge ? diff : shifted_lo;
    quo_next   = {quo_q[WIDTH-2:0], ge};
  end

  // Next-state logic for the FSM and the datapath registers.
  always_comb begin
    // NOTE: every _d is given its hold value first so no path can infer a latch.
    state_d     = state_q;
    divisor_d   = divisor_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          divisor_d = in2;
          rem_d     = '0;
          quo_d     = in1;
          cnt_d     = '0;
          state_d   = ST_BUSY;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_BUSY: begin
        rem_d = rem_next;
        quo_d = quo_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d     = ST_DONE;
          quotient_d  = quo_next;
          remainder_d = rem_next;
          dbz_d       = (divisor_q == '0);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers. Reset aborts any operation in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the datapath registers are reset too, so an abort leaves no stale operands behind.
      state_q     <= ST_IDLE;
      divisor_q   <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let all registers update from pre-edge values.
      state_q     <= state_d;
      divisor_q   <= divisor_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign ready       = (state_q != ST_BUSY);
  assign done        = (state_q == ST_DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_udivider_seq.sv
// Directed and random checks of udivider_seq against plain-arithmetic division.
module tb_udivider_seq;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] in1, in2;
  logic             ready, done, div_by_zero;
  logic [WIDTH-1:0] quotient, remainder;

  int errors = 0;
  int checks = 0;

  udivider_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in1(in1), .in2(in2),
    .ready(ready), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_q(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return (b == 0) ? {WIDTH{1'b1}} : a / b;
  endfunction

  function automatic logic [WIDTH-1:0] ref_r(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return (b == 0) ? a : a % b;
  endfunction

  // Start one operation from a negedge, wait for done, and check latency,
  // busy behaviour and results. If junk is set, operands and start are
  // toggled randomly while busy.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit junk);
    logic [WIDTH-1:0] pq, pr;
    logic             pd;
    int               cyc;
    bit               ready_bad, stable_bad;
    check("ready_before_start", ready, 1'b1);
    pq = quotient; pr = remainder; pd = div_by_zero;
    start = 1'b1; in1 = a; in2 = b;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    cyc = 0; ready_bad = 0; stable_bad = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (ready !== 1'b0) ready_bad = 1;
      if (quotient !== pq || remainder !== pr || div_by_zero !== pd) stable_bad = 1;
      if (junk) begin
        in1 = $urandom; in2 = $urandom;
        start = (cyc < WIDTH - 2) ? 1'($urandom_range(1)) : 1'b0;
      end
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("latency", cyc, WIDTH);
    check("ready_low_busy", ready_bad, 1'b0);
    check("outputs_stable_busy", stable_bad, 1'b0);
    check("ready_in_done", ready, 1'b1);
    check("quotient", quotient, ref_q(a, b));
    check("remainder", remainder, ref_r(a, b));
    check("div_by_zero", div_by_zero, (b == 0));
  endtask

  logic [WIDTH-1:0] ba [6];
  logic [WIDTH-1:0] bb [6];

  initial begin
    int  cyc;
    bit  saw_done;
    logic [WIDTH-1:0] a, b;

    rst_n = 1'b0; start = 1'b0; in1 = '0; in2 = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", ready, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_quotient", quotient, '0);
    check("rst_remainder", remainder, '0);
    check("rst_dbz", div_by_zero, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases, including the divide-by-zero behaviour and its recovery.
    run_op(32'd100, 32'd7, 1'b0);
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0);
    run_op(32'd5, 32'd9, 1'b0);
    run_op(32'd1234, 32'd0, 1'b0);
    run_op(32'd8, 32'd2, 1'b0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    run_op(32'd0, 32'd5, 1'b1);
    run_op(32'd1, 32'hFFFF_FFFF, 1'b0);
    run_op(32'd0, 32'd0, 1'b0);
    run_op(32'h8000_0000, 32'h8000_0001, 1'b1);

    // Start held high: operations issue back-to-back, one every WIDTH+1 cycles.
    for (int k = 0; k < 6; k++) begin
      ba[k] = $urandom;
      bb[k] = (k == 3) ? '0 : ($urandom >> $urandom_range(31));
    end
    start = 1'b1; in1 = ba[0]; in2 = bb[0];
    @(posedge clk); @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      cyc = 0;
      if (k > 0) begin
        @(posedge clk); @(negedge clk);
        cyc = 1;
      end
      while (done !== 1'b1 && cyc < 40) begin
        in1 = $urandom; in2 = $urandom;
        @(posedge clk); @(negedge clk);
        cyc++;
      end
      check("b2b_spacing", cyc, (k == 0) ? WIDTH : WIDTH + 1);
      check("b2b_quotient", quotient, ref_q(ba[k], bb[k]));
      check("b2b_remainder", remainder, ref_r(ba[k], bb[k]));
      check("b2b_dbz", div_by_zero, (bb[k] == 0));
      if (k < 5) begin
        in1 = ba[k+1]; in2 = bb[k+1];
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);

    // Reset during the tenth busy cycle aborts the operation without a done pulse.
    start = 1'b1; in1 = 32'd77; in2 = 32'd3;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_abort_busy", ready, 1'b0);
    rst_n = 1'b0;
    #1;
    check("abort_ready", ready, 1'b1);
    check("abort_done", done, 1'b0);
    check("abort_quotient", quotient, '0);
    check("abort_remainder", remainder, '0);
    check("abort_dbz", div_by_zero, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0) saw_done = 1;
    end
    check("no_done_after_abort", saw_done, 1'b0);
    run_op(32'd50, 32'd5, 1'b0);

    // Random operand pairs, with a zero divisor forced about 1% of the time.
    for (int k = 0; k < 2000; k++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(31);
      if ($urandom_range(99) == 0) b = '0;
      run_op(a, b, 1'(k % 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
